// File: rtl/dcpu16_arb.sv
// Round-robin arbiter giving the dcpu16 F bus (fetch/store) and G bus (operand load)
// turns on one single-port memory, with a per-transaction watchdog.
// Handshake: a master raises stb with adr/wre/dto and holds them stable until it sees
// ack. Ack is a one-cycle pulse. Err is only ever high together with ack.
module dcpu16_arb #(
   parameter int AW  = 16,
   parameter int DW  = 16,
   parameter int TMO = 16,
   parameter int CW  = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] f_adr,
   input  logic          f_stb,
   input  logic          f_wre,
   input  logic [DW-1:0] f_dto,
   output logic [DW-1:0] f_dti,
   output logic          f_ack,
   output logic          f_err,
   input  logic [AW-1:0] g_adr,
   input  logic          g_stb,
   input  logic          g_wre,
   input  logic [DW-1:0] g_dto,
   output logic [DW-1:0] g_dti,
   output logic          g_ack,
   output logic          g_err,
   output logic [AW-1:0] m_adr,
   output logic          m_stb,
   output logic          m_wre,
   output logic [DW-1:0] m_dto,
   input  logic [DW-1:0] m_dti,
   input  logic          m_ack,
   output logic [1:0]    gnt
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSF = 2'b01,
      BUSG = 2'b10
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

   state_t        state_q, state_d;
   logic          prio_q, prio_d;   // 0: F wins a tie, 1: G wins a tie
   logic [CW-1:0] cnt_q, cnt_d;

   logic sel_f, sel_g, sel_stb, oth_stb, ack_ok, expire;

   always_comb begin
      sel_f   = (state_q == BUSF);
      sel_g   = (state_q == BUSG);
      sel_stb = (sel_f & f_stb) | (sel_g & g_stb);
      oth_stb = (sel_f & g_stb) | (sel_g & f_stb);
      ack_ok  = sel_stb & m_ack;
      // A memory ack on the expiry cycle takes precedence over the watchdog.
      expire  = (TMO != 0) && sel_stb && !m_ack && (cnt_q == CNT_LAST);

      state_d = state_q;
      prio_d  = prio_q;
      cnt_d   = '0;
      case (state_q)
         IDLE: begin
            if (f_stb && g_stb) state_d = prio_q ? BUSG : BUSF;
            else if (f_stb)     state_d = BUSF;
            else if (g_stb)     state_d = BUSG;
         end
         BUSF, BUSG: begin
            if (ack_ok) begin
               // The acked master's own stb is not looked at, so a waiting peer always gets the next turn.
               state_d = oth_stb ? (sel_f ? BUSG : BUSF) : IDLE;
               prio_d  = sel_f;
            end else if (!sel_stb || expire) begin
               state_d = IDLE;
               prio_d  = sel_f;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      gnt   = state_q;
      m_stb = sel_stb & ~expire;
      m_adr = sel_f ? f_adr : (sel_g ? g_adr : '0);
      m_wre = sel_f ? f_wre : (sel_g ? g_wre : 1'b0);
      m_dto = sel_f ? f_dto : (sel_g ? g_dto : '0);
      // Gating with rst keeps a transaction aborted by reset from being acknowledged.
      f_ack = rst & sel_f & (ack_ok | expire);
      f_err = rst & sel_f & expire;
      g_ack = rst & sel_g & (ack_ok | expire);
      g_err = rst & sel_g & expire;
      f_dti = (rst & sel_f & ack_ok) ? m_dti : '0;
      g_dti = (rst & sel_g & ack_ok) ? m_dti : '0;
   end

endmodule

// File: tb/tb_dcpu16_arb.sv
// Bench for dcpu16_arb: directed scenarios followed by random master/slave traffic, all
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_dcpu16_arb;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int TMO = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] f_adr, g_adr, m_adr;
  logic          f_stb, f_wre, g_stb, g_wre, m_stb, m_wre, m_ack;
  logic [DW-1:0] f_dto, g_dto, m_dto, f_dti, g_dti, m_dti;
  logic          f_ack, f_err, g_ack, g_err;
  logic [1:0]    gnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: owner 0 none / 1 F / 2 G, turn = master that wins a tie
  int owner = 0;
  int turn  = 1;
  int cnt   = 0;
  logic e_f_ack, e_g_ack;

  always #5 clk = ~clk;

  dcpu16_arb #(.AW(AW), .DW(DW), .TMO(TMO), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .f_adr(f_adr), .f_stb(f_stb), .f_wre(f_wre), .f_dto(f_dto),
    .f_dti(f_dti), .f_ack(f_ack), .f_err(f_err),
    .g_adr(g_adr), .g_stb(g_stb), .g_wre(g_wre), .g_dto(g_dto),
    .g_dti(g_dti), .g_ack(g_ack), .g_err(g_err),
    .m_adr(m_adr), .m_stb(m_stb), .m_wre(m_wre), .m_dto(m_dto),
    .m_dti(m_dti), .m_ack(m_ack), .gnt(gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at the negative edge: predict every output from the model and the live inputs.
  task automatic cycle_check();
    logic gstb, acked, tmo;
    logic [63:0] e_bus, e_f, e_g;
    @(negedge clk);
    gstb  = (owner == 1) ? f_stb : ((owner == 2) ? g_stb : 1'b0);
    acked = (owner != 0) && gstb && m_ack;
    tmo   = (owner != 0) && gstb && !m_ack && (cnt == TMO - 1);
    e_bus = '0;
    if (owner == 1) e_bus = {(gstb && !tmo), f_wre, f_adr, f_dto};
    if (owner == 2) e_bus = {(gstb && !tmo), g_wre, g_adr, g_dto};
    e_f_ack = rst && (owner == 1) && (acked || tmo);
    e_g_ack = rst && (owner == 2) && (acked || tmo);
    e_f = {e_f_ack, rst && (owner == 1) && tmo, (rst && owner == 1 && acked) ? m_dti : 16'h0};
    e_g = {e_g_ack, rst && (owner == 2) && tmo, (rst && owner == 2 && acked) ? m_dti : 16'h0};
    chk("gnt", gnt, owner[1:0]);
    chk("m_bus", {m_stb, m_wre, m_adr, m_dto}, e_bus);
    chk("f_ret", {f_ack, f_err, f_dti}, e_f);
    chk("g_ret", {g_ack, g_err, g_dti}, e_g);
  endtask

  // Advance the model across the rising edge using the same inputs the DUT sampled.
  task automatic cycle_step();
    logic gstb, ostb, acked, tmo;
    int other;
    @(posedge clk);
    gstb  = (owner == 1) ? f_stb : ((owner == 2) ? g_stb : 1'b0);
    acked = (owner != 0) && gstb && m_ack;
    tmo   = (owner != 0) && gstb && !m_ack && (cnt == TMO - 1);
    other = 3 - owner;
    ostb  = (other == 1) ? f_stb : g_stb;
    if (!rst) begin
      owner = 0; turn = 1; cnt = 0;
    end else if (owner == 0) begin
      if (f_stb && g_stb) owner = turn;
      else if (f_stb)     owner = 1;
      else if (g_stb)     owner = 2;
      cnt = 0;
    end else if (acked) begin
      owner = ostb ? other : 0; turn = other; cnt = 0;
    end else if (!gstb || tmo) begin
      owner = 0; turn = other; cnt = 0;
    end else begin
      cnt++;
    end
    #1;
  endtask

  task automatic cycle();
    cycle_check();
    cycle_step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    f_stb = 0; f_wre = 0; f_adr = '0; f_dto = '0;
    g_stb = 0; g_wre = 0; g_adr = '0; g_dto = '0;
    m_ack = 0; m_dti = '0;
    cycle();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_out", {m_stb, m_adr, f_ack, g_ack, f_dti, g_dti}, '0);
    rst = 1'b1;
  endtask

  task automatic f_new();
    f_stb = 1'b1; f_adr = 16'($urandom); f_wre = 1'($urandom_range(0, 1)); f_dto = 16'($urandom);
  endtask

  task automatic g_new();
    g_stb = 1'b1; g_adr = 16'($urandom); g_wre = 1'($urandom_range(0, 1)); g_dto = 16'($urandom);
  endtask

  initial begin
    // 1: F-only read, memory acks on the second granted cycle
    do_reset();
    f_stb = 1; f_adr = 16'h0010;
    cycle();
    cycle_check();
    chk("t1_mstb", {m_stb, gnt}, 3'b1_01);
    cycle_step();
    m_ack = 1; m_dti = 16'hBEEF;
    cycle_check();
    chk("t1_ack", {f_ack, f_err, f_dti}, {2'b10, 16'hBEEF});
    cycle_step();
    f_stb = 0; m_ack = 0;
    cycle_check();
    chk("t1_idle", gnt, 2'b00);
    cycle_step();

    // 2: simultaneous requests after reset, F first, handover without idle
    do_reset();
    f_stb = 1; g_stb = 1; f_adr = 16'h1111; g_adr = 16'h2222;
    cycle();
    m_ack = 1; m_dti = 16'h00F0;
    cycle_check();
    chk("t2_f", {gnt, f_ack}, 3'b01_1);
    cycle_step();
    f_stb = 0; m_dti = 16'h0A0A;
    cycle_check();
    chk("t2_g", {gnt, g_ack, g_dti}, {3'b10_1, 16'h0A0A});
    cycle_step();
    g_stb = 0; m_ack = 0;
    cycle();

    // 3: continuous requests, memory always ready -> strict alternation
    do_reset();
    f_stb = 1; g_stb = 1; m_ack = 1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      f_adr = 16'($urandom); g_adr = 16'($urandom); m_dti = 16'($urandom);
      cycle_check();
      chk("t3_alt", gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
      cycle_step();
    end
    f_stb = 0; g_stb = 0; m_ack = 0;
    cycle();

    // 4: G write that the memory never acknowledges
    do_reset();
    g_stb = 1; g_wre = 1; g_adr = 16'hDEAD; g_dto = 16'h5555;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    cycle_check();
    chk("t4_tmo", {g_ack, g_err, m_stb, gnt}, 5'b110_10);
    cycle_step();
    g_stb = 0;
    cycle_check();
    chk("t4_idle", gnt, 2'b00);
    cycle_step();

    // 5: reset lands on the same edge as a memory ack
    do_reset();
    f_stb = 1;
    cycle();
    cycle();
    rst = 0; m_ack = 1;
    cycle_check();
    chk("t5_noack", {f_ack, f_err}, 2'b00);
    cycle_step();
    rst = 1; m_ack = 0; g_stb = 1;
    cycle_check();
    chk("t5_zero", {gnt, m_stb, f_ack, g_ack}, '0);
    cycle_step();
    cycle_check();
    chk("t5_prio", gnt, 2'b01);
    cycle_step();
    f_stb = 0; g_stb = 0;
    cycle();

    // 6: F write acked exactly on the last watchdog count
    do_reset();
    f_stb = 1; f_wre = 1; f_adr = 16'h0300; f_dto = 16'h1234;
    cycle();
    for (int i = 0; i < TMO - 1; i++) cycle();
    m_ack = 1;
    cycle_check();
    chk("t6_late", {f_ack, f_err, m_stb, m_wre, m_dto}, {4'b1011, 16'h1234});
    cycle_step();
    f_stb = 0; m_ack = 0;
    cycle();

    // 7: granted master withdraws its request; no ack and G gets the next tie
    do_reset();
    f_stb = 1;
    cycle();
    f_stb = 0;
    cycle_check();
    chk("t7_noack", {f_ack, f_err, m_stb}, 3'b000);
    cycle_step();
    f_stb = 1; g_stb = 1;
    cycle();
    cycle_check();
    chk("t7_prio", gnt, 2'b10);
    cycle_step();
    f_stb = 0; g_stb = 0;
    cycle();

    // Random traffic: protocol-abiding masters, erratic memory, occasional reset
    do_reset();
    for (int i = 0; i < 800; i++) begin
      cycle();
      if (e_f_ack) begin
        if ($urandom_range(0, 1) == 1) f_new(); else f_stb = 0;
      end else if (!f_stb && $urandom_range(0, 2) == 0) begin
        f_new();
      end
      if (e_g_ack) begin
        if ($urandom_range(0, 1) == 1) g_new(); else g_stb = 0;
      end else if (!g_stb && $urandom_range(0, 2) == 0) begin
        g_new();
      end
      m_ack = ($urandom_range(0, 99) < 35);
      m_dti = 16'($urandom);
      rst   = ($urandom_range(0, 149) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
